// File: rtl/athos_pkg.sv
// athos_pkg: shared types and constants for the ATHOS GF operators
package athos_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} gf_frob_state_e;
  localparam logic [8:0] GF_AES_POLY = 9'h11B;
  typedef struct packed {
    logic [7:0] a;
    logic [3:0] k;
    logic [8:0] poly;
    logic       raw;
  } gf_frob_req_t;
endpackage

// File: rtl/gf_sqr_reduce.sv
// gf_sqr_reduce: one carry-less square of op, optionally reduced mod poly
module gf_sqr_reduce #(
  parameter int M = 8
) (
  input  logic [M-1:0]   op,
  input  logic [M:0]     poly,
  input  logic           raw,
  output logic [2*M-1:0] nxt
);
  logic [2*M-1:0] sq, r;
  always_comb begin
    sq = '0;
    for (int i = 0; i < M; i++) sq[2*i] = op[i];
    r = sq;
    for (int i = 2*M-2; i >= M; i--) r = r[i] ? r ^ ((2*M)'(poly) << (i-M)) : r;
    nxt = raw ? sq : {{M{1'b0}}, r[M-1:0]};
  end
endmodule

// File: rtl/gf_frob_pow.sv
// gf_frob_pow: iterative a^(2^k) mod p(x), one square-and-reduce per clock
// ATHOS_GF_FROB_UNROLL2_EN chains two squarers so BUSY retires two steps per cycle
module gf_frob_pow
  import athos_pkg::*;
#(
  parameter int         M        = 8,
  parameter int         KW       = 4,
  parameter logic [M:0] DEF_POLY = (M+1)'(GF_AES_POLY)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [M-1:0]   op_a_i,
  input  logic [KW-1:0]  k_i,
  input  logic [M:0]     poly_i,
  input  logic           raw_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [2*M-1:0] res_o,
  output logic           busy_o
);
  gf_frob_state_e state;
  logic [2*M-1:0] acc, s1, nxt;
  logic [KW-1:0]  cnt, step;
  logic [M:0]     poly_q;
  logic           raw_q;

  gf_sqr_reduce #(.M(M)) u_sq1 (.op(acc[M-1:0]), .poly(poly_q), .raw(raw_q), .nxt(s1));

`ifdef ATHOS_GF_FROB_UNROLL2_EN
  logic [2*M-1:0] s2;
  gf_sqr_reduce #(.M(M)) u_sq2 (.op(s1[M-1:0]), .poly(poly_q), .raw(raw_q), .nxt(s2));
  // raw requests always carry cnt==1, so they take the single-step path
  assign step = (cnt == KW'(1)) ? KW'(1) : KW'(2);
  assign nxt  = (cnt == KW'(1)) ? s1 : s2;
`else
  assign step = KW'(1);
  assign nxt  = s1;
`endif

  assign res_o = (state == DONE) ? acc : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      poly_q      <= DEF_POLY;
      raw_q       <= 1'b0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid_i) begin
        acc        <= {{M{1'b0}}, op_a_i};
        cnt        <= raw_i ? KW'(1) : k_i;
        poly_q     <= poly_i | (M+1)'(1) << M;
        raw_q      <= raw_i;
        in_ready_o <= 1'b0;
        busy_o     <= 1'b1;
        if (!raw_i && k_i == '0) begin
          state       <= DONE;
          out_valid_o <= 1'b1;
        end else state <= BUSY;
      end
    end else if (state == BUSY) begin
      acc <= nxt;
      cnt <= cnt - step;
      if (cnt <= step) begin
        state       <= DONE;
        out_valid_o <= 1'b1;
      end
    end else if (out_ready_i) begin
      state       <= IDLE;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      busy_o      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gf_frob_pow.sv
// tb_gf_frob_pow: directed checks of gf_frob_pow with hand-computed results
module tb_gf_frob_pow;
`ifdef ATHOS_GF_FROB_UNROLL2_EN
  localparam bit UNR = 1'b1;
`else
  localparam bit UNR = 1'b0;
`endif
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, raw = 0, out_valid, out_ready = 0, busy;
  logic [7:0]  op_a = 0;
  logic [3:0]  k_in = 0;
  logic [8:0]  poly = 9'h11B;
  logic [15:0] res;
  int          cmps = 0, errs = 0;

  gf_frob_pow dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_a_i(op_a), .k_i(k_in), .poly_i(poly), .raw_i(raw),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .res_o(res), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int k, input bit r);
    return r ? 2 : (UNR ? (k + 1) / 2 + 1 : k + 1);
  endfunction

  task automatic start(input logic [7:0] a, input logic [3:0] k, input logic [8:0] p, input logic r);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("ready_before_accept", 32'(in_ready), 1);
    op_a = a; k_in = k; poly = p; raw = r; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [15:0] exp);
    int n = 1;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_res"}, 32'(res), 32'(exp));
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
  endtask

  task automatic retire(input string tag);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({tag, "_ret_valid"}, 32'(out_valid), 0);
    chk({tag, "_ret_ready"}, 32'(in_ready), 1);
    chk({tag, "_ret_res"}, 32'(res), 0);
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [3:0] k,
                     input logic [8:0] p, input logic r, input logic [15:0] exp);
    start(a, k, p, r);
    wait_done(tag, lat(int'(k), r), exp);
    retire(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_res", 32'(res), 0);
    chk("rst_busy", 32'(busy), 0);

    run("aes_k1", 8'h53, 4'd1, 9'h11B, 1'b0, 16'h00B5);
    run("raw_ff", 8'hFF, 4'd5, 9'h000, 1'b1, 16'h5555);
    run("k8_identity", 8'h53, 4'd8, 9'h11B, 1'b0, 16'h0053);
    run("k0_pass", 8'hA7, 4'd0, 9'h11B, 1'b0, 16'h00A7);
    run("x_k2", 8'h02, 4'd2, 9'h11B, 1'b0, 16'h0010);
    run("x_k3", 8'h02, 4'd3, 9'h11B, 1'b0, 16'h001B);
    run("x_k4", 8'h02, 4'd4, 9'h11B, 1'b0, 16'h005E);
    run("x_k8", 8'h02, 4'd8, 9'h11B, 1'b0, 16'h0002);
    run("one_k15", 8'h01, 4'd15, 9'h11B, 1'b0, 16'h0001);
    // bit 8 of poly is forced high internally
    run("poly_msb0", 8'h53, 4'd1, 9'h01B, 1'b0, 16'h00B5);

    start(8'h53, 4'd1, 9'h11B, 1'b0);
    wait_done("bp", 2, 16'h00B5);
    op_a = 8'h11; k_in = 4'd0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_res", 32'(res), 32'h00B5);
      chk("bp_hold_ready", 32'(in_ready), 0);
    end
    in_valid = 0;
    retire("bp");
    chk("bp_idle_busy", 32'(busy), 0);

    start(8'h53, 4'd10, 9'h11B, 1'b0);
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_res", 32'(res), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    run("post_rst", 8'h02, 4'd2, 9'h11B, 1'b0, 16'h0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
